// File: rtl/vga_timing_480p.sv
// Display timing generator for 640x480 @ 60 Hz VGA: beam position counters,
// sync pulses, data enable and line/frame strobes, all on the pixel clock.
module vga_timing_480p #(
  parameter int CORDW    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_MAX  = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX  = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] HA_END = CORDW'(H_ACTIVE - 1);
  localparam logic [CORDW-1:0] HS_STA = CORDW'(H_ACTIVE - 1 + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE - 1 + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VA_END = CORDW'(V_ACTIVE - 1);
  localparam logic [CORDW-1:0] VS_STA = CORDW'(V_ACTIVE - 1 + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE - 1 + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] ONE    = CORDW'(1);

  localparam logic H_ACT_LVL = (H_POL != 0);
  localparam logic V_ACT_LVL = (V_POL != 0);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx <= '0;
      sy <= '0;
    end else if (sx == H_MAX) begin
      sx <= '0;
      sy <= (sy == V_MAX) ? '0 : sy + ONE;
    end else begin
      sx <= sx + ONE;
    end
  end

  // Decodes are purely combinational so they line up with sx/sy exactly.
  always_comb begin
    hsync = (sx > HS_STA && sx <= HS_END) ? H_ACT_LVL : ~H_ACT_LVL;
    vsync = (sy > VS_STA && sy <= VS_END) ? V_ACT_LVL : ~V_ACT_LVL;
    de    = (sx <= HA_END) && (sy <= VA_END);
    line  = (sx == '0);
    frame = (sx == '0) && (sy == '0);
  end

endmodule

// File: tb/tb_vga_timing_480p.sv
// Scoreboard bench for vga_timing_480p: a default 640x480 instance for line
// timing and a reduced-geometry instance so whole frames fit in a short run.
module tb_vga_timing_480p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, rst_s;
  logic [9:0] sx_d, sy_d;
  logic [4:0] sx_s, sy_s;
  logic       hs_d, vs_d, de_d, ln_d, fr_d;
  logic       hs_s, vs_s, de_s, ln_s, fr_s;

  vga_timing_480p dut_d (
    .clk_pix(clk), .rst_pix(rst_d), .sx(sx_d), .sy(sy_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .line(ln_d), .frame(fr_d)
  );

  // Small geometry: 16+4+6+4 = 30 px/line, 8+2+2+3 = 15 lines, 450 cycles/frame
  vga_timing_480p #(
    .CORDW(5), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(0), .V_POL(0)
  ) dut_s (
    .clk_pix(clk), .rst_pix(rst_s), .sx(sx_s), .sy(sy_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .line(ln_s), .frame(fr_s)
  );

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ln;
    logic       fr;
  } exp_t;

  exp_t qd[$];
  exp_t qs[$];

  int checks = 0;
  int errors = 0;
  int mdx = 0, mdy = 0, msx = 0, msy = 0;
  int cycle = 0;
  int last_fr_s = -1, last_ln_d = -1;
  int n_hs_d, n_vs_d, n_de_d, n_ln_d;
  int n_hs_s, n_vs_s, n_de_s, n_ln_s, n_fr_s;

  function automatic exp_t decode(input int x, input int y, input int ha,
                                  input int hl, input int hh, input int va,
                                  input int vl, input int vh);
    exp_t e;
    e.sx = 10'(x);
    e.sy = 10'(y);
    e.hs = !(x >= hl && x <= hh);
    e.vs = !(y >= vl && y <= vh);
    e.de = (x < ha) && (y < va);
    e.ln = (x == 0);
    e.fr = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    n_hs_d = 0; n_vs_d = 0; n_de_d = 0; n_ln_d = 0;
    n_hs_s = 0; n_vs_s = 0; n_de_s = 0; n_ln_s = 0; n_fr_s = 0;
  endtask

  task automatic tick(input logic rd, input logic rs);
    exp_t ed, es;
    rst_d = rd;
    rst_s = rs;
    if (rd) begin mdx = 0; mdy = 0; end
    else if (mdx == 799) begin mdx = 0; mdy = (mdy == 524) ? 0 : mdy + 1; end
    else mdx++;
    if (rs) begin msx = 0; msy = 0; end
    else if (msx == 29) begin msx = 0; msy = (msy == 14) ? 0 : msy + 1; end
    else msx++;
    qd.push_back(decode(mdx, mdy, 640, 656, 751, 480, 490, 491));
    qs.push_back(decode(msx, msy, 16, 20, 25, 8, 10, 11));
    @(posedge clk);
    @(negedge clk);
    cycle++;
    ed = qd.pop_front();
    es = qs.pop_front();
    chk("d_sx", sx_d, ed.sx);   chk("d_sy", sy_d, ed.sy);
    chk("d_hsync", hs_d, ed.hs); chk("d_vsync", vs_d, ed.vs);
    chk("d_de", de_d, ed.de);   chk("d_line", ln_d, ed.ln);
    chk("d_frame", fr_d, ed.fr);
    chk("s_sx", {5'b0, sx_s}, es.sx); chk("s_sy", {5'b0, sy_s}, es.sy);
    chk("s_hsync", hs_s, es.hs); chk("s_vsync", vs_s, es.vs);
    chk("s_de", de_s, es.de);   chk("s_line", ln_s, es.ln);
    chk("s_frame", fr_s, es.fr);
    if (!hs_d) n_hs_d++;
    if (!vs_d) n_vs_d++;
    if (de_d)  n_de_d++;
    if (ln_d)  n_ln_d++;
    if (!hs_s) n_hs_s++;
    if (!vs_s) n_vs_s++;
    if (de_s)  n_de_s++;
    if (ln_s)  n_ln_s++;
    if (fr_s)  n_fr_s++;
    if (rs) last_fr_s = -1;
    else if (fr_s) begin
      if (last_fr_s >= 0) chk("s_frame_period", cycle - last_fr_s, 450);
      last_fr_s = cycle;
    end
    if (rd) last_ln_d = -1;
    else if (ln_d) begin
      if (last_ln_d >= 0) chk("d_line_period", cycle - last_ln_d, 800);
      last_ln_d = cycle;
    end
  endtask

  task automatic run_until_s(input int tx, input int ty, input int limit);
    int n = 0;
    while (!(msx == tx && msy == ty) && n < limit) begin tick(1'b0, 1'b0); n++; end
    checks++;
    assert (msx == tx && msy == ty) else begin
      errors++;
      $error("FAIL s_reach: observed sx=%0d sy=%0d expected sx=%0d sy=%0d within %0d cycles",
             sx_s, sy_s, tx, ty, limit);
    end
  endtask

  task automatic run_until_d(input int tx, input int limit);
    int n = 0;
    while (mdx != tx && n < limit) begin tick(1'b0, 1'b0); n++; end
    checks++;
    assert (mdx == tx) else begin
      errors++;
      $error("FAIL d_reach: observed sx=%0d expected sx=%0d within %0d cycles", sx_d, tx, limit);
    end
  endtask

  int sy_before;

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    clear_stats();

    // Reset held three cycles
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_sx", sx_d, 0);   chk("rst_sy", sy_d, 0);
    chk("rst_hsync", hs_d, 1); chk("rst_vsync", vs_d, 1);
    chk("rst_de", de_d, 1);   chk("rst_line", ln_d, 1);
    chk("rst_frame", fr_d, 1);

    tick(1'b0, 1'b0);
    chk("release_sx", sx_d, 1);
    chk("release_frame", fr_d, 0);
    chk("release_s_sx", sx_s, 1);

    // 7200 = lcm(800, 450): whole lines of the default and whole small frames
    clear_stats();
    repeat (7200) tick(1'b0, 1'b0);
    chk("d_hs_low_cnt", n_hs_d, 9 * 96);
    chk("d_line_cnt", n_ln_d, 9);
    chk("d_de_cnt", n_de_d, 9 * 640);
    chk("d_vs_low_cnt", n_vs_d, 0);
    chk("s_hs_low_cnt", n_hs_s, 16 * 15 * 6);
    chk("s_vs_low_cnt", n_vs_s, 16 * 2 * 30);
    chk("s_de_cnt", n_de_s, 16 * 16 * 8);
    chk("s_line_cnt", n_ln_s, 16 * 15);
    chk("s_frame_cnt", n_fr_s, 16);

    // Default line wrap
    run_until_d(799, 900);
    sy_before = mdy;
    tick(1'b0, 1'b0);
    chk("d_wrap_sx", sx_d, 0);
    chk("d_wrap_sy", sy_d, sy_before + 1);
    chk("d_wrap_line", ln_d, 1);

    // Hsync edges on the default geometry
    run_until_d(655, 900);
    chk("d_hs_655", hs_d, 1);
    tick(1'b0, 1'b0);
    chk("d_hs_656", hs_d, 0);
    run_until_d(751, 900);
    chk("d_hs_751", hs_d, 0);
    tick(1'b0, 1'b0);
    chk("d_hs_752", hs_d, 1);

    // Small frame wrap
    run_until_s(29, 14, 500);
    tick(1'b0, 1'b0);
    chk("s_fwrap_sx", sx_s, 0);
    chk("s_fwrap_sy", sy_s, 0);
    chk("s_fwrap_frame", fr_s, 1);

    // Mid-frame reset inside both sync pulses on the small instance
    run_until_s(22, 10, 500);
    chk("s_insync_hs", hs_s, 0);
    chk("s_insync_vs", vs_s, 0);
    tick(1'b0, 1'b1);
    chk("s_midrst_sx", sx_s, 0);  chk("s_midrst_sy", sy_s, 0);
    chk("s_midrst_hs", hs_s, 1);  chk("s_midrst_vs", vs_s, 1);
    chk("s_midrst_de", de_s, 1);
    tick(1'b0, 1'b0);
    chk("s_restart_sx", sx_s, 1);

    // Mid-line reset inside hsync on the default instance
    run_until_d(700, 900);
    chk("d_insync_hs", hs_d, 0);
    tick(1'b1, 1'b0);
    chk("d_midrst_sx", sx_d, 0);  chk("d_midrst_sy", sy_d, 0);
    chk("d_midrst_hs", hs_d, 1);  chk("d_midrst_vs", vs_d, 1);
    chk("d_midrst_de", de_d, 1);  chk("d_midrst_frame", fr_d, 1);
    tick(1'b0, 1'b0);
    chk("d_restart_sx", sx_d, 1);
    repeat (500) tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
